ts_channel_selector: RTL



---
 rtl/ts_channel_selector.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ts_channel_selector.sv
`default_nettype none
// ============================================================================
// Module   : ts_channel_selector
// Purpose  : N-channel TS input selector with presence tracking, priority
//            fallback, revert hold-off and packet-aligned switching.
// Revision : 1.0
// ============================================================================
module ts_channel_selector #(
  parameter int NUM_CH      = 4,
  parameter int TMR_W       = 20,
  parameter int DEF_TIMEOUT = 2250,
  parameter int DEF_HOLDOFF = 750000,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     i_ch_valid,
  input  logic [NUM_CH-1:0]     i_ch_sync,
  input  logic                  i_mm_write_en,
  input  logic                  i_mm_read_en,
  input  logic [7:0]            i_mm_addr,
  input  logic [31:0]           i_mm_wdata,
  output logic [31:0]           o_mm_rdata,
  output logic [CH_W-1:0]       o_sel_channel,
  output logic                  o_sel_valid,
  output logic [NUM_CH-1:0]     o_ch_present,
  output logic                  o_switch_pulse
);

  localparam logic [7:0] c_ADDR_CTRL    = 8'h00;
  localparam logic [7:0] c_ADDR_PRIO    = 8'h01;
  localparam logic [7:0] c_ADDR_TIMEOUT = 8'h02;
  localparam logic [7:0] c_ADDR_HOLDOFF = 8'h03;
  localparam logic [7:0] c_ADDR_STATUS  = 8'h04;
  localparam logic [7:0] c_ADDR_SWCNT   = 8'h05;
  localparam int         c_PRIO_W       = NUM_CH * CH_W;

  typedef enum logic [1:0] {
    S_LOCKED    = 2'd0,
    S_HOLDOFF   = 2'd1,
    S_WAIT_SYNC = 2'd2
  } state_t;

  // Configuration registers
  logic                r_fallback_en;
  logic                r_manual_en;
  logic [CH_W-1:0]     r_manual_ch;
  logic [c_PRIO_W-1:0] r_prio;
  logic [TMR_W-1:0]    r_timeout;
  logic [TMR_W-1:0]    r_holdoff;
  logic [31:0]         r_sw_count;

  // Selection state
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_sel;
  logic [CH_W-1:0]     r_target;
  logic [CH_W-1:0]     w_target_nxt;
  logic [TMR_W-1:0]    r_hold_cnt;
  logic                w_hold_clr;
  logic                w_commit;
  logic                r_sel_valid;
  logic                r_switch_pulse;
  logic [31:0]         r_rdata;
  logic [31:0]         w_rdata;

  logic [TMR_W-1:0]    w_timeout_eff;
  logic [NUM_CH-1:0]   w_present;
  logic [CH_W-1:0]     w_cand;
  logic                w_found;
  logic [CH_W-1:0]     w_entry;
  logic                w_to_holdoff;
  logic                w_unused;

  assign w_unused = ^i_mm_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fallback_en <= 1'b1;
      r_manual_en   <= 1'b0;
      r_manual_ch   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_prio[k*CH_W +: CH_W] <= CH_W'(k);
      end
      r_timeout     <= TMR_W'(DEF_TIMEOUT);
      r_holdoff     <= TMR_W'(DEF_HOLDOFF);
    end else if (i_mm_write_en) begin
      case (i_mm_addr)
        c_ADDR_CTRL: begin
          r_fallback_en <= i_mm_wdata[0];
          r_manual_en   <= i_mm_wdata[1];
          r_manual_ch   <= i_mm_wdata[CH_W+1:2];
        end
        c_ADDR_PRIO:    r_prio    <= i_mm_wdata[c_PRIO_W-1:0];
        c_ADDR_TIMEOUT: r_timeout <= i_mm_wdata[TMR_W-1:0];
        c_ADDR_HOLDOFF: r_holdoff <= i_mm_wdata[TMR_W-1:0];
        default: ;
      endcase
    end
  end

  // A zero timeout would make every channel permanently absent
  assign w_timeout_eff = (r_timeout == '0) ? TMR_W'(1) : r_timeout;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_presence
      logic [TMR_W-1:0] r_pcnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pcnt <= '1;
        end else if (i_ch_valid[i]) begin
          r_pcnt <= '0;
        end else if (r_pcnt < w_timeout_eff) begin
          r_pcnt <= r_pcnt + TMR_W'(1);
        end
      end
      assign w_present[i] = (r_pcnt < w_timeout_eff);
    end
  endgenerate

  function automatic logic [CH_W:0] f_rank(input logic [CH_W-1:0] ch,
                                           input logic [c_PRIO_W-1:0] prio);
    f_rank = (CH_W+1)'(NUM_CH);
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (prio[k*CH_W +: CH_W] == ch) f_rank = (CH_W+1)'(k);
    end
  endfunction

  always_comb begin
    w_cand  = r_sel;
    w_found = 1'b0;
    w_entry = '0;
    if (r_manual_en) begin
      if (int'(r_manual_ch) < NUM_CH) w_cand = r_manual_ch;
    end else if (r_fallback_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        w_entry = r_prio[k*CH_W +: CH_W];
        if (!w_found && (int'(w_entry) < NUM_CH) && w_present[w_entry]) begin
          w_cand  = w_entry;
          w_found = 1'b1;
        end
      end
    end else begin
      w_entry = r_prio[CH_W-1:0];
      if (int'(w_entry) < NUM_CH) w_cand = w_entry;
    end
  end

  // Reverting to a better channel while the current one is healthy is delayed
  assign w_to_holdoff = !r_manual_en && w_present[r_sel] &&
                        (f_rank(w_cand, r_prio) < f_rank(r_sel, r_prio));

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_hold_clr   = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_LOCKED: begin
        if (w_cand != r_sel) begin
          w_target_nxt = w_cand;
          w_hold_clr   = 1'b1;
          w_state_nxt  = w_to_holdoff ? S_HOLDOFF : S_WAIT_SYNC;
        end
      end
      S_HOLDOFF: begin
        if (w_cand == r_sel) begin
          w_state_nxt = S_LOCKED;
        end else if (w_cand != r_target) begin
          w_target_nxt = w_cand;
          w_hold_clr   = 1'b1;
          w_state_nxt  = w_to_holdoff ? S_HOLDOFF : S_WAIT_SYNC;
        end else if (r_hold_cnt >= r_holdoff) begin
          w_state_nxt = S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (w_cand == r_sel) begin
          w_state_nxt = S_LOCKED;
        end else if (w_cand != r_target) begin
          w_target_nxt = w_cand;
          w_hold_clr   = 1'b1;
          w_state_nxt  = w_to_holdoff ? S_HOLDOFF : S_WAIT_SYNC;
        end else if (i_ch_valid[r_target] && i_ch_sync[r_target]) begin
          w_commit    = 1'b1;
          w_state_nxt = S_LOCKED;
        end
      end
      default: w_state_nxt = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_LOCKED;
      r_target       <= '0;
      r_sel          <= '0;
      r_hold_cnt     <= '0;
      r_switch_pulse <= 1'b0;
      r_sel_valid    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_target       <= w_target_nxt;
      r_switch_pulse <= w_commit;
      r_sel_valid    <= w_present[r_sel];
      if (w_commit) r_sel <= r_target;
      if (w_hold_clr) begin
        r_hold_cnt <= '0;
      end else if ((r_state == S_HOLDOFF) && (r_hold_cnt != '1)) begin
        r_hold_cnt <= r_hold_cnt + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_count <= '0;
    end else if (i_mm_write_en && (i_mm_addr == c_ADDR_SWCNT)) begin
      r_sw_count <= '0;
    end else if (w_commit) begin
      r_sw_count <= r_sw_count + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_mm_addr)
      c_ADDR_CTRL: begin
        w_rdata[0]        = r_fallback_en;
        w_rdata[1]        = r_manual_en;
        w_rdata[CH_W+1:2] = r_manual_ch;
      end
      c_ADDR_PRIO:    w_rdata[c_PRIO_W-1:0] = r_prio;
      c_ADDR_TIMEOUT: w_rdata[TMR_W-1:0]    = r_timeout;
      c_ADDR_HOLDOFF: w_rdata[TMR_W-1:0]    = r_holdoff;
      c_ADDR_STATUS: begin
        w_rdata[CH_W-1:0]   = r_sel;
        w_rdata[8 +: NUM_CH] = w_present;
        w_rdata[16]         = r_sel_valid;
      end
      c_ADDR_SWCNT:   w_rdata = r_sw_count;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_mm_read_en) begin
      r_rdata <= w_rdata;
    end
  end

  assign o_mm_rdata     = r_rdata;
  assign o_sel_channel  = r_sel;
  assign o_sel_valid    = r_sel_valid;
  assign o_ch_present   = w_present;
  assign o_switch_pulse = r_switch_pulse;

endmodule
`default_nettype wire
